// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per RUN cycle.
// Define ADDSUB_SAT_EN to saturate S on signed overflow.
module digit_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad
        $error("digit_serial_add_sub: illegal WIDTH/DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx, d_ext, s_fin;
    logic [DIGIT-1:0] a_d, b_d;
    logic [DIGIT:0]   dsum;
    logic [CW-1:0]    cnt;
    logic             carry, last, c_msb, v_fin;

    assign a_d   = a_sh[DIGIT-1:0];
    assign b_d   = b_sh[DIGIT-1:0];
    assign dsum  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    assign last  = (cnt == LAST);
    // Carry into the top bit of the current digit, recovered from its sum bit.
    assign c_msb = dsum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
    assign v_fin = c_msb ^ dsum[DIGIT];

    // Sum digits enter at the top and shift down, landing at counter*DIGIT.
    assign d_ext  = WIDTH'(dsum[DIGIT-1:0]);
    assign acc_nx = (acc >> DIGIT) | (d_ext << (WIDTH - DIGIT));

`ifdef ADDSUB_SAT_EN
    always_comb begin
        s_fin = acc_nx;
        if (v_fin) begin
            s_fin = a_d[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_fin = acc_nx;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
            N     <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_sh  <= A;
                b_sh  <= B ^ {WIDTH{M}};
                acc   <= '0;
                carry <= M;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            acc   <= acc_nx;
            carry <= dsum[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                S    <= s_fin;
                Cout <= dsum[DIGIT];
                V    <= v_fin;
                Z    <= ~|s_fin;
                N    <= s_fin[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: DIGIT=4, 1 and 16 instances vs arithmetic model.
// Build with ADDSUB_SAT_EN defined to check the saturating variant.
module tb_digit_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid[3];
    logic        in_ready[3];
    logic [15:0] a_i[3];
    logic [15:0] b_i[3];
    logic        m_i[3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [15:0] s[3];
    logic        cout[3], v[3], z[3], n[3];

    int checks = 0;
    int errors = 0;
    int ndig[3] = '{4, 16, 1};

    always #5 clk = ~clk;

    digit_serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_i[0]), .B(b_i[0]), .M(m_i[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .S(s[0]), .Cout(cout[0]), .V(v[0]), .Z(z[0]), .N(n[0])
    );

    digit_serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_i[1]), .B(b_i[1]), .M(m_i[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .S(s[1]), .Cout(cout[1]), .V(v[1]), .Z(z[1]), .N(n[1])
    );

    digit_serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_i[2]), .B(b_i[2]), .M(m_i[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .S(s[2]), .Cout(cout[2]), .V(v[2]), .Z(z[2]), .N(n[2])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic, signed range test for overflow.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         input logic m, output logic [15:0] rs,
                         output logic rc, output logic rv,
                         output logic rz, output logic rn);
        logic [16:0] full;
        int sa, sb, r;
        full = {1'b0, a} + {1'b0, (m ? ~b : b)} + 17'(m);
        rs = full[15:0];
        rc = full[16];
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? sa - sb : sa + sb;
        rv = (r > 32767) || (r < -32768);
`ifdef ADDSUB_SAT_EN
        if (rv) rs = (r > 32767) ? 16'h7FFF : 16'h8000;
`endif
        rz = (rs == 16'h0000);
        rn = rs[15];
    endtask

    task automatic run_op(input int k, input logic [15:0] a,
                          input logic [15:0] b, input logic m);
        logic [15:0] es;
        logic ec, ev, ez, en;
        int edges;
        bit done;
        string p;
        p = $sformatf("k%0d_%h_%h_%0d", k, a, b, m);
        model(a, b, m, es, ec, ev, ez, en);
        @(negedge clk);
        a_i[k] = a; b_i[k] = b; m_i[k] = m;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        @(posedge clk); #1;
        edges = 0;
        done = 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            in_valid[k] = 1'($urandom);
            a_i[k] = 16'($urandom);
            b_i[k] = 16'($urandom);
            m_i[k] = 1'($urandom);
            @(posedge clk); #1;
            edges++;
            if (out_valid[k]) done = 1;
            else check({p, "_rdy_run"}, 32'(in_ready[k]), 32'd0);
        end
        check({p, "_lat"}, 32'(edges), 32'(ndig[k]));
        check({p, "_S"}, 32'(s[k]), 32'(es));
        check({p, "_C"}, 32'(cout[k]), 32'(ec));
        check({p, "_V"}, 32'(v[k]), 32'(ev));
        check({p, "_Z"}, 32'(z[k]), 32'(ez));
        check({p, "_N"}, 32'(n[k]), 32'(en));
        repeat (5) begin
            @(negedge clk);
            in_valid[k] = 1'($urandom);
            a_i[k] = 16'($urandom);
            b_i[k] = 16'($urandom);
            m_i[k] = 1'($urandom);
            @(posedge clk); #1;
            check({p, "_bp_vld"}, 32'(out_valid[k]), 32'd1);
            check({p, "_bp_S"}, 32'(s[k]), 32'(es));
            check({p, "_bp_rdy"}, 32'(in_ready[k]), 32'd0);
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        check({p, "_idle_vld"}, 32'(out_valid[k]), 32'd0);
        check({p, "_idle_rdy"}, 32'(in_ready[k]), 32'd1);
        check({p, "_idle_S"}, 32'(s[k]), 32'(es));
        check({p, "_idle_V"}, 32'(v[k]), 32'(ev));
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic check_reset(input string tag, input int k);
        check({tag, "_S"}, 32'(s[k]), 32'd0);
        check({tag, "_C"}, 32'(cout[k]), 32'd0);
        check({tag, "_V"}, 32'(v[k]), 32'd0);
        check({tag, "_Z"}, 32'(z[k]), 32'd0);
        check({tag, "_N"}, 32'(n[k]), 32'd0);
        check({tag, "_vld"}, 32'(out_valid[k]), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            a_i[k] = '0;
            b_i[k] = '0;
            m_i[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) check_reset($sformatf("rst%0d", k), k);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            run_op(k, 16'h1234, 16'h0FFF, 1'b0);
            run_op(k, 16'h0005, 16'h0007, 1'b1);
            run_op(k, 16'h1234, 16'h1234, 1'b1);
            run_op(k, 16'h7FFF, 16'h0001, 1'b0);
            run_op(k, 16'h8000, 16'h0001, 1'b1);
            run_op(k, 16'h8000, 16'h8000, 1'b0);
            run_op(k, 16'h0000, 16'h0000, 1'b0);
        end

        // Abandon an operation two digit edges into RUN.
        @(negedge clk);
        a_i[0] = 16'h4321; b_i[0] = 16'h1111; m_i[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midrun", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 16'h4321, 16'h1111, 1'b0);

        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 3; k++) begin
                run_op(k, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_add_sub.md
Name: digit_serial_add_sub

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock, with a single DIGIT-wide carry chain reused across cycles, trading latency for area. Sits in the datapath wherever a full-width carry chain is too large or too slow. Valid/ready on input and output, plus carry, overflow, zero and negative flags.

Parameters:
WIDTH, 16, operand/result width in bits; >= 2.
DIGIT, 4, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).
NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operands and mode valid
in_ready   output  1      block can accept an operation
A          input   WIDTH  operand A
B          input   WIDTH  operand B
M          input   1      mode: 0 = A+B, 1 = A-B (A + ~B + 1)
out_valid  output  1      result and flags valid
out_ready  input   1      consumer accepts the result
S          output  WIDTH  result
Cout       output  1      carry out of MSB (for M=1: 1 = no borrow)
V          output  1      signed overflow = carry into MSB XOR Cout
Z          output  1      S == 0
N          output  1      S[WIDTH-1]

Behaviour:
- Reset (rst_n=0, async): state=IDLE, digit counter=0, carry=0.
  - S=0, Cout=0, V=0, Z=0, N=0, out_valid=0, in_ready=1 on reset assert.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a clock edge (accept edge): latch A, B^{WIDTH{M}} and M; carry <= M; counter <= 0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge adds digit[counter] of A and of the modified B with the carry register.
  - Writes DIGIT sum bits into the result register at bit offset counter*DIGIT; updates the carry register; counter++.
  - On the edge with counter==NDIG-1: capture Cout = carry out of bit WIDTH-1, and V = carry into bit WIDTH-1 XOR Cout. Go to DONE.
- Latency: out_valid is high exactly NDIG edges after the accept edge (4 for the defaults).
- DONE:
  - out_valid=1; S/Cout/V/Z/N are stable and held while out_ready=0 (unbounded backpressure).
  - On out_ready=1 at an edge: go to IDLE.
  - in_ready stays 0 in DONE; no same-cycle accept. Minimum issue interval is NDIG+2 cycles.
- Output updates:
  - S changes only on the final RUN edge. Intermediate digits accumulate in an internal register, not on S.
  - S, Cout, V, Z and N keep the last result in IDLE until the next operation completes.
- Z and N are derived from the final registered S.
- Arithmetic wraps modulo 2^WIDTH; no width extension.
- DIGIT=WIDTH is legal: NDIG=1, one RUN edge. DIGIT=1 gives a fully bit-serial block.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined: on V=1, S saturates.
  - Positive overflow (A[MSB]=0) -> 0 followed by all ones, e.g. 0x7FFF.
  - Negative overflow (A[MSB]=1) -> 1 followed by all zeros, e.g. 0x8000.
  - V still reports 1. Cout is the raw carry. Z and N reflect the saturated S.
- Not defined: S is the wrapped result. No saturation logic is present.

Test Plan:
- WIDTH=16, DIGIT=4: A=0x1234, B=0x0FFF, M=0 -> S=0x2233, Cout=0, V=0, Z=0, N=0; out_valid exactly 4 edges after accept; in_ready=0 during RUN and DONE.
- A=0x0005, B=0x0007, M=1 -> S=0xFFFE, Cout=0, V=0, N=1. Then A=0x1234, B=0x1234, M=1 -> S=0x0000, Cout=1, Z=1.
- A=0x7FFF, B=0x0001, M=0 -> V=1, Cout=0; S=0x8000 with N=1, or S=0x7FFF with N=0 under ADDSUB_SAT_EN. A=0x8000, B=0x0001, M=1 -> V=1, Cout=1; S=0x7FFF, or 0x8000 under ADDSUB_SAT_EN.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and S unchanged.
  - Toggle in_valid and change A/B/M during RUN and DONE -> result unaffected, nothing accepted.
  - out_ready=1 -> IDLE next edge.
- Assert rst_n=0 mid-RUN (after 2 digit edges) -> all outputs 0 and in_ready=1 immediately without a clock edge. A fresh operation after release completes correctly.
- Repeat the add/sub/overflow vectors with DIGIT=1 (16-edge latency) and DIGIT=16 (1-edge latency) -> identical S and flags.
